// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: bus widths, the NOP encoding, vector addresses and
// the IF/ID register control bundle.
package fetch_stage_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [7:0] NOP            = 8'h00;
  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] INTR_VEC_ADDR  = 8'h01;

  // At most one of flush/load/imm_cap is set in any cycle; none set means hold
  typedef struct packed {
    logic flush;
    logic load;
    logic imm_cap;
  } if_id_ctl_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: opcode, immediate, pc+1 and valid, with
// flush-to-NOP, opcode load and immediate-only capture.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = fetch_stage_pkg::ADDR_W,
  parameter int DATA_W = fetch_stage_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  if_id_ctl_t        ctl,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] pc_plus1_in,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr    <= DATA_W'(NOP);
      imm      <= '0;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (ctl.flush) begin
      instr <= DATA_W'(NOP);
      imm   <= '0;
      valid <= 1'b0;
    end else if (ctl.load) begin
      instr    <= data;
      pc_plus1 <= pc_plus1_in;
      valid    <= 1'b1;
    end else if (ctl.imm_cap) begin
      imm <= data;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, boots from the reset vector, applies
// redirects and vectors accepted interrupts through the ISR vector.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               ADDR_W         = fetch_stage_pkg::ADDR_W,
  parameter int               DATA_W         = fetch_stage_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = ADDR_W'(fetch_stage_pkg::RESET_VEC_ADDR),
  parameter logic [ADDR_W-1:0] INTR_VEC_ADDR  = ADDR_W'(fetch_stage_pkg::INTR_VEC_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              pc_write_en,
  input  logic              if_id_write_en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ret_taken,
  input  logic [ADDR_W-1:0] ret_pc,
  input  logic              intr,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              int_inject,
  output logic [ADDR_W-1:0] int_ret_pc,
  output logic              intr_ack
);
  typedef enum logic [1:0] {S_RST_VEC, S_RUN, S_INT_VEC} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic              intr_prev, intr_pending, intr_rise;
  logic              run, redirect, accept;
  if_id_ctl_t        ctl;

  assign pc_inc    = pc + ADDR_W'(1);
  assign intr_rise = intr & ~intr_prev;
  assign run       = (state == S_RUN);
  assign redirect  = ret_taken | branch_taken;
  // Requiring if_id_write_en keeps an interrupt out of a two-byte instruction
  assign accept    = run & ~redirect & intr_pending & if_id_write_en & pc_write_en;

  always_comb begin
    case (state)
      S_RUN:     imem_addr = pc;
      S_INT_VEC: imem_addr = INTR_VEC_ADDR;
      default:   imem_addr = RESET_VEC_ADDR;
    endcase
  end

  always_comb begin
    ctl         = '0;
    ctl.flush   = (state == S_RST_VEC) | (run & (redirect | accept));
    ctl.load    = run & ~redirect & ~accept & pc_write_en & if_id_write_en;
    ctl.imm_cap = run & ~redirect & pc_write_en & ~if_id_write_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_RST_VEC;
      pc           <= '0;
      intr_prev    <= 1'b0;
      intr_pending <= 1'b0;
      int_ret_pc   <= '0;
      int_inject   <= 1'b0;
      intr_ack     <= 1'b0;
    end else begin
      intr_prev  <= intr;
      int_inject <= 1'b0;
      intr_ack   <= 1'b0;
      // An edge landing on the accept cycle merges into the request being taken
      if (accept)         intr_pending <= 1'b0;
      else if (intr_rise) intr_pending <= 1'b1;
      case (state)
        S_RST_VEC, S_INT_VEC: begin
          pc    <= ADDR_W'(imem_data);
          state <= S_RUN;
        end
        S_RUN: begin
          if (ret_taken)         pc <= ret_pc;
          else if (branch_taken) pc <= branch_target;
          else if (accept) begin
            int_ret_pc <= pc;
            int_inject <= 1'b1;
            intr_ack   <= 1'b1;
            state      <= S_INT_VEC;
          end else if (pc_write_en) pc <= pc_inc;
        end
        default: state <= S_RST_VEC;
      endcase
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .ctl         (ctl),
    .data        (imem_data),
    .pc_plus1_in (pc_inc),
    .instr       (if_id_instr),
    .imm         (if_id_imm),
    .pc_plus1    (if_id_pc_plus1),
    .valid       (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage;
  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] imem_addr, imem_data;
  logic       pc_write_en = 1'b1, if_id_write_en = 1'b1;
  logic       branch_taken = 1'b0, ret_taken = 1'b0, intr = 1'b0;
  logic [7:0] branch_target = 8'h00, ret_pc = 8'h00;
  logic [7:0] if_id_instr, if_id_imm, if_id_pc_plus1, int_ret_pc;
  logic       if_id_valid, int_inject, intr_ack;

  logic [7:0] mem [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret_taken(ret_taken), .ret_pc(ret_pc), .intr(intr),
    .if_id_instr(if_id_instr), .if_id_imm(if_id_imm),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
    .int_inject(int_inject), .int_ret_pc(int_ret_pc), .intr_ack(intr_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: "booting" means the next edge loads PC from the reset
  // vector, "vectoring" means the next edge loads PC from the ISR vector.
  bit         m_boot = 1, m_vec = 0, m_valid = 0, m_prev = 0, m_pend = 0;
  logic [7:0] m_pc = 0, m_instr = 0, m_imm = 0, m_pp1 = 0, m_ret = 0;

  function automatic logic [7:0] m_addr();
    return m_boot ? 8'h00 : (m_vec ? 8'h01 : m_pc);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot = 1; m_vec = 0; m_valid = 0; m_prev = 0; m_pend = 0;
      m_pc = 0; m_instr = 0; m_imm = 0; m_pp1 = 0; m_ret = 0;
    end else begin
      logic [7:0] d;
      bit took;
      d = mem[m_addr()];
      took = 0;
      if (m_boot) begin
        m_pc = d; m_boot = 0; m_instr = 0; m_imm = 0; m_valid = 0;
      end else if (m_vec) begin
        m_pc = d; m_vec = 0;
      end else if (ret_taken || branch_taken) begin
        m_pc = ret_taken ? ret_pc : branch_target;
        m_instr = 0; m_imm = 0; m_valid = 0;
      end else if (m_pend && if_id_write_en && pc_write_en) begin
        m_ret = m_pc; m_instr = 0; m_imm = 0; m_valid = 0; m_vec = 1; took = 1;
      end else if (pc_write_en && !if_id_write_en) begin
        m_imm = d; m_pc = m_pc + 8'd1;
      end else if (pc_write_en) begin
        m_instr = d; m_pp1 = m_pc + 8'd1; m_valid = 1; m_pc = m_pc + 8'd1;
      end
      if (took) m_pend = 0;
      else if (intr && !m_prev) m_pend = 1;
      m_prev = intr;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("imem_addr", imem_addr, m_addr());
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_imm", if_id_imm, m_imm);
      chk("if_id_pc_plus1", if_id_pc_plus1, m_pp1);
      chk("if_id_valid", if_id_valid, m_valid);
      chk("int_inject", int_inject, m_vec);
      chk("intr_ack", intr_ack, m_vec);
      chk("int_ret_pc", int_ret_pc, m_ret);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hE0; mem[8'h10] = 8'h21;
    mem[8'h20] = 8'hC1; mem[8'h21] = 8'h5A; mem[8'hFF] = 8'h77;

    // reset state and boot
    repeat (2) @(posedge clk); #2;
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_instr", if_id_instr, 8'h00);
    chk("rst_ack", intr_ack, 1'b0);
    rst = 1'b1;
    tick(); chk("boot_pc", imem_addr, 8'h10);
    tick(); chk("boot_instr", if_id_instr, 8'h21);
    chk("boot_valid", if_id_valid, 1'b1);
    chk("boot_pp1", if_id_pc_plus1, 8'h11);

    // two-byte instruction
    branch_taken = 1; branch_target = 8'h20;
    tick(); branch_taken = 0;
    chk("br_pc", imem_addr, 8'h20); chk("br_flush", if_id_valid, 1'b0);
    tick(); chk("op_instr", if_id_instr, 8'hC1);
    if_id_write_en = 0;
    tick(); if_id_write_en = 1;
    chk("imm_val", if_id_imm, 8'h5A); chk("imm_hold", if_id_instr, 8'hC1);
    chk("imm_pc", imem_addr, 8'h22);

    // ret beats branch
    branch_taken = 1; branch_target = 8'h40; ret_taken = 1; ret_pc = 8'h80;
    tick(); branch_taken = 0; ret_taken = 0;
    chk("ret_pc", imem_addr, 8'h80); chk("ret_flush", if_id_valid, 1'b0);

    // interrupt at PC=33
    branch_taken = 1; branch_target = 8'h33;
    tick(); branch_taken = 0; pc_write_en = 0; intr = 1;
    tick(); pc_write_en = 1; intr = 0;
    chk("stall_pc", imem_addr, 8'h33);
    tick();
    chk("int_ack", intr_ack, 1'b1); chk("int_inj", int_inject, 1'b1);
    chk("int_ret", int_ret_pc, 8'h33); chk("int_vec", imem_addr, 8'h01);
    tick();
    chk("int_ack_end", intr_ack, 1'b0); chk("isr_pc", imem_addr, 8'hE0);

    // interrupt deferred across immediate capture
    if_id_write_en = 0; intr = 1;
    tick(); intr = 0; chk("defer_ack0", intr_ack, 1'b0);
    tick(); chk("defer_ack1", intr_ack, 1'b0);
    if_id_write_en = 1;
    tick(); chk("defer_take", intr_ack, 1'b1); chk("defer_ret", int_ret_pc, 8'hE2);
    tick();

    // PC wrap and full stall
    branch_taken = 1; branch_target = 8'hFF;
    tick(); branch_taken = 0;
    tick(); chk("wrap_pp1", if_id_pc_plus1, 8'h00);
    chk("wrap_pc", imem_addr, 8'h00); chk("wrap_instr", if_id_instr, 8'h77);
    pc_write_en = 0;
    repeat (3) begin
      tick();
      chk("stall_addr", imem_addr, 8'h00); chk("stall_instr", if_id_instr, 8'h77);
      chk("stall_pp1", if_id_pc_plus1, 8'h00);
    end
    pc_write_en = 1;

    // asynchronous reset mid-cycle
    tick(); #1 rst = 0; #1;
    chk("arst_addr", imem_addr, 8'h00); chk("arst_valid", if_id_valid, 1'b0);
    chk("arst_instr", if_id_instr, 8'h00); chk("arst_ret", int_ret_pc, 8'h00);
    #1 rst = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      ret_taken      = ($urandom_range(15) == 0);
      branch_taken   = ($urandom_range(9) == 0);
      ret_pc         = 8'($urandom);
      branch_target  = 8'($urandom);
      pc_write_en    = ($urandom_range(4) != 0);
      if_id_write_en = ($urandom_range(3) != 0);
      if ($urandom_range(5) == 0) intr = ~intr;
      if (c == 1500) begin
        #1 rst = 0; #2 rst = 1;
      end
    end
    ret_taken = 0; branch_taken = 0; intr = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
